aes_inv_sbox_seq: RTL and testbench

Sequential AES inverse S-box (InvSubBytes) engine: takes one byte over a valid/ready handshake, applies the inverse affine transform, then computes the GF(2^8) multiplicative inverse by iterative square-and-multiply. It returns the result over a second valid/ready handshake. It is the decode-direction counterpart of the combinational forward S-box lookup and serves datapaths where area matters more than throughput. It also provides a self-check path for the forward table.

---
 rtl/aes_gf_pkg.sv | 46 ++++
 rtl/aes_gf_mul.sv | 15 +
 rtl/aes_inv_sbox_seq.sv | 85 ++++++++
 tb/tb_aes_inv_sbox_seq.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_gf_pkg.sv
// Shared GF(2^8) definitions for the AES inverse S-box engine and future
// MixColumns/InvMixColumns datapaths. Field polynomial is x^8+x^4+x^3+x+1.
package aes_gf_pkg;

   // Low byte of the field polynomial 0x11B; the x^8 term is implicit.
   localparam logic [7:0] AES_RED_POLY = 8'h1B;
   // Constant of the inverse affine transform.
   localparam logic [7:0] INV_AFFINE_C = 8'h05;
   // Square-and-multiply steps needed to reach b^254.
   localparam int unsigned EXP_ITERS = 7;

   typedef enum logic [1:0] {
      IDLE,
      EXP,
      DONE
   } aes_state_e;

   // Inverse affine transform: rotl(a,1) ^ rotl(a,3) ^ rotl(a,6) ^ 0x05.
   function automatic logic [7:0] inv_affine(input logic [7:0] a);
      logic [7:0] r1;
      logic [7:0] r3;
      logic [7:0] r6;
      r1 = {a[6:0], a[7]};
      r3 = {a[4:0], a[7:5]};
      r6 = {a[1:0], a[7:2]};
      return r1 ^ r3 ^ r6 ^ INV_AFFINE_C;
   endfunction

   // Carry-less 8x8 product (15 bits) reduced modulo 0x11B, high bit first.
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [14:0] prod;
      prod = '0;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) begin
            prod = prod ^ (15'(a) << i);
         end
      end
      for (int i = 14; i >= 8; i--) begin
         if (prod[i]) begin
            prod = prod ^ (15'({1'b1, AES_RED_POLY}) << (i - 8));
         end
      end
      return prod[7:0];
   endfunction

endpackage

// File: rtl/aes_gf_mul.sv
// Combinational GF(2^8) multiplier over the AES field.
module aes_gf_mul
   import aes_gf_pkg::*;
(
   input  logic [7:0] a,
   input  logic [7:0] b,
   output logic [7:0] p
);

   // Product is a pure function of the two operands.
   always_comb begin
      p = gf_mul(a, b);
   end

endmodule

// File: rtl/aes_inv_sbox_seq.sv
// Sequential AES inverse S-box: inverse affine on capture, then b^254 by
// seven square-and-multiply steps, result returned over a valid/ready port.
module aes_inv_sbox_seq
   import aes_gf_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] in_byte,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] out_byte
);

   aes_state_e state;
   logic [7:0] sq;
   logic [7:0] acc;
   logic [2:0] cnt;
   logic [7:0] s2;
   logic [7:0] acc_next;

   // Squarer: sq -> sq^2 each EXP cycle.
   aes_gf_mul u_sqr (
      .a (sq),
      .b (sq),
      .p (s2)
   );

   // Accumulator multiplier folds the fresh square into the running product.
   aes_gf_mul u_acc (
      .a (acc),
      .b (s2),
      .p (acc_next)
   );

   // Control FSM with registered handshake outputs and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out_byte  <= 8'h00;
         sq        <= 8'h00;
         acc       <= 8'h00;
         cnt       <= 3'd0;
      end else begin
         unique case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  sq       <= inv_affine(in_byte);
                  acc      <= 8'h01;
                  cnt      <= 3'd0;
                  in_ready <= 1'b0;
                  state    <= EXP;
               end
            end
            EXP: begin
               sq  <= s2;
               acc <= acc_next;
               cnt <= cnt + 3'd1;
               // Last step: acc_next = b^(2+4+...+128) = b^-1 (0 maps to 0).
               if (cnt == 3'(EXP_ITERS - 1)) begin
                  out_byte  <= acc_next;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_aes_inv_sbox_seq.sv
// Directed bench for aes_inv_sbox_seq: golden vectors, latency, backpressure,
// mid-operation reset, full round-trip through the forward S-box, streaming.
module tb_aes_inv_sbox_seq;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_byte;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_byte;

   int errors;
   int checks;

   logic [7:0] sbox [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
      8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
      8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
      8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
      8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
      8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
      8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
      8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
      8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
      8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
      8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
      8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
      8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
      8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
      8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
      8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
      8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   aes_inv_sbox_seq dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_byte   (in_byte),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_byte  (out_byte)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One full transaction with latency check; out_ready pulsed once valid.
   task automatic xfer(input string tag, input logic [7:0] b, input logic [7:0] exp);
      int n;
      n = 0;
      while (!in_ready && n < 20) begin
         tick();
         n++;
      end
      check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      in_byte  = b;
      tick();
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 20) begin
         tick();
         n++;
      end
      check({tag, "_latency"}, 32'(n), 32'd7);
      check({tag, "_byte"}, 32'(out_byte), 32'(exp));
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   initial begin
      int cyc;
      int got;
      int sent;
      int last;
      logic acc_now;

      errors    = 0;
      checks    = 0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_byte   = 8'h00;
      out_ready = 1'b0;

      // Reset state.
      #12;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_byte", 32'(out_byte), 32'h00);
      rst_n = 1'b1;
      tick();

      // Zero after affine: 0x63 -> 0x00, in_ready low across all of EXP.
      in_valid = 1'b1;
      in_byte  = 8'h63;
      tick();
      in_valid = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         check("exp_in_ready", 32'(in_ready), 32'd0);
         check("exp_out_valid", 32'(out_valid), 32'd0);
         tick();
      end
      check("exp_in_ready_last", 32'(in_ready), 32'd0);
      tick();
      check("z_out_valid", 32'(out_valid), 32'd1);
      check("z_in_ready", 32'(in_ready), 32'd0);
      check("z_out_byte", 32'(out_byte), 32'h00);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("z_in_ready_back", 32'(in_ready), 32'd1);
      check("z_out_valid_drop", 32'(out_valid), 32'd0);

      // Golden vectors.
      xfer("v7c", 8'h7c, 8'h01);
      xfer("v16", 8'h16, 8'hff);
      xfer("v00", 8'h00, 8'h52);
      xfer("ved", 8'hed, 8'h53);

      // Backpressure: hold DONE 5 cycles with a competing in_valid.
      in_valid = 1'b1;
      in_byte  = 8'h16;
      tick();
      in_byte  = 8'h7c;
      cyc = 0;
      while (!out_valid && cyc < 20) begin
         tick();
         cyc++;
      end
      for (int k = 0; k < 5; k++) begin
         check("bp_out_valid", 32'(out_valid), 32'd1);
         check("bp_out_byte", 32'(out_byte), 32'hff);
         check("bp_in_ready", 32'(in_ready), 32'd0);
         tick();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("bp_release_valid", 32'(out_valid), 32'd0);
      check("bp_release_ready", 32'(in_ready), 32'd1);
      tick();
      tick();
      check("bp_no_capture", 32'(out_valid), 32'd0);
      check("bp_idle_ready", 32'(in_ready), 32'd1);

      // Reset during the third EXP cycle.
      in_valid = 1'b1;
      in_byte  = 8'hed;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      check("mid_rst_out_valid", 32'(out_valid), 32'd0);
      check("mid_rst_in_ready", 32'(in_ready), 32'd1);
      #3;
      rst_n = 1'b1;
      tick();
      check("post_rst_out_valid", 32'(out_valid), 32'd0);
      xfer("post_rst_7c", 8'h7c, 8'h01);

      // Round trip through the forward table for every byte.
      for (int x = 0; x < 256; x++) begin
         xfer("rt", sbox[x], 8'(x));
      end

      // Streaming with out_ready tied high.
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_byte   = sbox[3];
      sent = 0;
      got  = 0;
      last = 0;
      cyc  = 0;
      while (got < 16 && cyc < 400) begin
         acc_now = in_valid & in_ready;
         check("st_excl", 32'(in_ready & out_valid), 32'd0);
         if (out_valid) begin
            check("st_byte", 32'(out_byte), 32'(got * 16 + 3));
            if (got > 0) begin
               check("st_spacing", 32'(cyc - last), 32'd9);
            end
            last = cyc;
            got++;
         end
         tick();
         cyc++;
         if (acc_now) begin
            sent++;
            if (sent < 16) begin
               in_byte = sbox[sent * 16 + 3];
            end else begin
               in_valid = 1'b0;
            end
         end
      end
      check("st_count", 32'(got), 32'd16);
      check("st_sent", 32'(sent), 32'd16);
      tick();
      tick();
      check("st_tail_valid", 32'(out_valid), 32'd0);
      out_ready = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
